slice_ff_readback: RTL and testbench

Serial readback engine for slice storage elements (FF/latch models, including ZINI-encoded ones). On a capture request it snapshots `NUM_FF` parallel Q values and undoes the ZINI inversion so the snapshot holds true logical values. It then streams the bits out one per accepted transfer on a valid/ready serial port. It is the reading end of the slice state path: primitives hold state, and this block extracts it for bitstream/readback verification benches.

---
 rtl/slice_ff_readback_if.sv | 25 ++
 rtl/slice_ff_readback.sv | 91 +++++++++
 tb/tb_slice_ff_readback.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/slice_ff_readback_if.sv
// Serial readback port bundle: capture request, parallel Q snapshot input,
// and the valid/ready serial output with status flags.
interface slice_ff_readback_if #(
   parameter int NUM_FF = 8
);
   logic              CAPTURE;
   logic [NUM_FF-1:0] Q_IN;
   logic              DOUT;
   logic              DOUT_VALID;
   logic              DOUT_READY;
   logic              BUSY;
   logic              DONE;

   // Requester side: asks for a capture and consumes the serial stream.
   modport master (
      output CAPTURE, Q_IN, DOUT_READY,
      input  DOUT, DOUT_VALID, BUSY, DONE
   );

   // Readback engine side.
   modport slave (
      input  CAPTURE, Q_IN, DOUT_READY,
      output DOUT, DOUT_VALID, BUSY, DONE
   );
endinterface

// File: rtl/slice_ff_readback.sv
// Serial readback engine: snapshots NUM_FF storage bits on request, undoes
// ZINI inversion, and streams the true values out one bit per transfer.
module slice_ff_readback #(
   parameter int                NUM_FF    = 8,
   parameter logic [NUM_FF-1:0] ZINI_MASK = '0,
   parameter bit                MSB_FIRST = 1'b0
) (
   input logic                 C,
   input logic                 R,
   slice_ff_readback_if.slave  bus
);
   localparam int CW = $clog2(NUM_FF + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [NUM_FF-1:0] sreg, sreg_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              dout_q, dout_n;
   logic              valid_q, valid_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   logic              xfer;

   // Transfer uses the registered valid so no input reaches an output
   // without passing through a flop.
   assign xfer = valid_q & bus.DOUT_READY;

   // Next-state, next-snapshot and next registered outputs.
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
      case (state)
         S_IDLE: begin
            if (bus.CAPTURE) begin
               sreg_n  = bus.Q_IN ^ ZINI_MASK;
               cnt_n   = CW'(NUM_FF);
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (xfer) begin
               // Move the next bit toward the output end, zero fill.
               sreg_n = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
               cnt_n  = cnt - CW'(1);
               if (cnt == CW'(1)) state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      valid_n = (state_n == S_SHIFT);
      busy_n  = (state_n != S_IDLE);
      done_n  = (state_n == S_DONE);
      // DOUT is forced low whenever no valid bit is presented.
      dout_n  = valid_n & (MSB_FIRST ? sreg_n[NUM_FF-1] : sreg_n[0]);
   end

   // State, snapshot, counter and output registers; reset discards any
   // readback in flight.
   always_ff @(posedge C) begin
      if (R) begin
         state   <= S_IDLE;
         sreg    <= '0;
         cnt     <= '0;
         dout_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_n;
         sreg    <= sreg_n;
         cnt     <= cnt_n;
         dout_q  <= dout_n;
         valid_q <= valid_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   end

   assign bus.DOUT       = dout_q;
   assign bus.DOUT_VALID = valid_q;
   assign bus.BUSY       = busy_q;
   assign bus.DONE       = done_q;
endmodule

// File: tb/tb_slice_ff_readback.sv
// Bench for slice_ff_readback: three configurations run in lockstep
// (8-bit LSB-first, 8-bit ZINI 0x0F MSB-first, 1-bit ZINI 1) against a
// bit-index reference model, plus directed sequence checks.
module tb_slice_ff_readback;
   logic       C;
   logic       R;
   logic       cap;
   logic [7:0] q8;
   logic       q1;
   logic       rdy;

   int checks = 0;
   int errors = 0;

   slice_ff_readback_if #(.NUM_FF(8)) ia ();
   slice_ff_readback_if #(.NUM_FF(8)) ib ();
   slice_ff_readback_if #(.NUM_FF(1)) ic ();

   assign ia.CAPTURE = cap;  assign ia.Q_IN = q8;  assign ia.DOUT_READY = rdy;
   assign ib.CAPTURE = cap;  assign ib.Q_IN = q8;  assign ib.DOUT_READY = rdy;
   assign ic.CAPTURE = cap;  assign ic.Q_IN = q1;  assign ic.DOUT_READY = rdy;

   slice_ff_readback #(.NUM_FF(8), .ZINI_MASK(8'h00), .MSB_FIRST(1'b0))
      u_a (.C(C), .R(R), .bus(ia));
   slice_ff_readback #(.NUM_FF(8), .ZINI_MASK(8'h0F), .MSB_FIRST(1'b1))
      u_b (.C(C), .R(R), .bus(ib));
   slice_ff_readback #(.NUM_FF(1), .ZINI_MASK(1'b1), .MSB_FIRST(1'b0))
      u_c (.C(C), .R(R), .bus(ic));

   initial C = 1'b0;
   always #5 C = ~C;

   // Reference model: phase 0 idle, 1 streaming, 2 done pulse.
   int         nb[3]   = '{8, 8, 1};
   logic [7:0] mk[3]   = '{8'h00, 8'h0F, 8'h01};
   bit         msbf[3] = '{1'b0, 1'b1, 1'b0};
   int         ph[3];
   int         sent[3];
   logic [7:0] snap[3];
   logic [63:0] rx[3];
   int          rxn[3];

   logic ov[3], od[3], ob[3], odn[3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample();
      ov[0] = ia.DOUT_VALID; od[0] = ia.DOUT; ob[0] = ia.BUSY; odn[0] = ia.DONE;
      ov[1] = ib.DOUT_VALID; od[1] = ib.DOUT; ob[1] = ib.BUSY; odn[1] = ib.DONE;
      ov[2] = ic.DOUT_VALID; od[2] = ic.DOUT; ob[2] = ic.BUSY; odn[2] = ic.DONE;
   endtask

   task automatic clear_rx();
      for (int d = 0; d < 3; d++) begin rx[d] = '0; rxn[d] = 0; end
   endtask

   // One clock: drive inputs, log observed transfers, advance the model,
   // then compare every output of every instance just after the edge.
   task automatic tick(input bit r, input bit c, input logic [7:0] qv,
                       input bit q1v, input bit rd);
      logic [7:0] qd;
      int         idx;
      bit         ev;
      R = r; cap = c; q8 = qv; q1 = q1v; rdy = rd;
      sample();
      for (int d = 0; d < 3; d++) begin
         if (!r && ov[d] === 1'b1 && rd) begin
            rx[d][rxn[d]] = od[d];
            rxn[d]++;
         end
         qd = (d < 2) ? qv : {7'b0, q1v};
         if (r) begin
            ph[d] = 0; sent[d] = 0;
         end else begin
            case (ph[d])
               0: if (c) begin
                     snap[d] = (qd ^ mk[d]) & 8'((1 << nb[d]) - 1);
                     sent[d] = 0; ph[d] = 1;
                  end
               1: if (rd) begin
                     sent[d]++;
                     if (sent[d] == nb[d]) ph[d] = 2;
                  end
               default: ph[d] = 0;
            endcase
         end
      end
      @(posedge C); #1;
      sample();
      for (int d = 0; d < 3; d++) begin
         idx = msbf[d] ? (nb[d] - 1 - sent[d]) : sent[d];
         ev  = (ph[d] == 1) ? snap[d][idx] : 1'b0;
         chk($sformatf("d%0d_valid", d), 64'(ov[d]),  64'(ph[d] == 1));
         chk($sformatf("d%0d_busy",  d), 64'(ob[d]),  64'(ph[d] != 0));
         chk($sformatf("d%0d_done",  d), 64'(odn[d]), 64'(ph[d] == 2));
         chk($sformatf("d%0d_dout",  d), 64'(od[d]),  64'(ev));
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin ph[d] = 0; sent[d] = 0; snap[d] = '0; end
      clear_rx();
      R = 1'b1; cap = 1'b0; q8 = '0; q1 = 1'b0; rdy = 1'b0;

      // Reset state.
      tick(1, 0, 8'h00, 0, 0);
      tick(1, 1, 8'hFF, 1, 1);
      tick(0, 0, 8'h00, 0, 0);

      // Basic readback: A5 LSB-first, AA MSB-first after ZINI, 1-bit ZINI.
      clear_rx();
      tick(0, 1, 8'hA5, 1, 1);
      for (int i = 0; i < 10; i++) tick(0, 0, 8'h00, 0, 1);
      chk("a5_seq_a", rx[0][7:0], 64'hA5);
      chk("a5_n_a",   64'(rxn[0]), 64'd8);
      chk("aa_seq_b", rx[1][7:0], 64'h55);
      chk("one_seq_c", rx[2][0], 64'd0);
      chk("one_n_c",  64'(rxn[2]), 64'd1);

      // Backpressure with ready pattern 0,0,1,0,1,...
      clear_rx();
      tick(0, 1, 8'h01, 0, 0);
      tick(0, 0, 8'h00, 0, 0);
      tick(0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 20; i++) tick(0, 0, 8'h00, 0, (i % 2) == 0);
      chk("bp_seq_a", rx[0][7:0], 64'h01);
      chk("bp_n_a",   64'(rxn[0]), 64'd8);
      chk("bp_seq_b", rx[1][7:0], 64'h70);

      // Capture during shift is ignored; snapshot isolated from Q_IN.
      clear_rx();
      tick(0, 1, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) tick(0, 1, 8'hFF, 1, 1);
      for (int i = 0; i < 8; i++) tick(0, 0, 8'hFF, 1, 1);
      chk("ign_seq_a", rx[0][7:0], 64'h00);
      chk("ign_n_a",   64'(rxn[0]), 64'd8);

      // Reset after the third transfer, then a clean 3C readback.
      tick(0, 1, 8'hA5, 1, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 8'h00, 0, 1);
      tick(1, 0, 8'h00, 0, 1);
      clear_rx();
      tick(0, 1, 8'h3C, 0, 1);
      for (int i = 0; i < 10; i++) tick(0, 0, 8'h00, 0, 1);
      chk("rst_seq_a", rx[0][7:0], 64'h3C);
      chk("rst_n_a",   64'(rxn[0]), 64'd8);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++)
         tick(($urandom % 60) == 0, ($urandom % 4) == 0, 8'($urandom),
              1'($urandom), ($urandom % 3) != 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
